// File: rtl/mux_pkg.sv
// mux_pkg: shared definitions for the scanning N:1 lane multiplexer.
//   mode_e     - mode input encoding (manual select / automatic scan)
//   sel_act_e  - resolved select-register action for one cycle, in priority order
//   sel_width  - select width for a given channel count (never narrower than 1 bit)
package mux_pkg;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        ACT_LOAD   = 2'd0,  // legal host load
        ACT_REJECT = 2'd1,  // host load of a nonexistent channel
        ACT_SCAN   = 2'd2,  // dwell counting / auto-advance
        ACT_HOLD   = 2'd3   // manual mode, nothing to do
    } sel_act_e;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_next_finder.sv
// rr_next_finder: combinational circular search for the next set bit in a mask
// strictly after a given index, wrapping CHANNELS-1 -> 0.
//   mask_i  [CHANNELS]  candidate mask
//   cur_i   [SEL_W]     starting index (must be < CHANNELS)
//   next_o  [SEL_W]     first enabled index after cur_i; cur_i itself when it is
//                       the only enabled bit; cur_i when nothing is enabled
//   found_o             at least one bit of mask_i is set
module rr_next_finder
    import mux_pkg::*;
#(
    parameter int CHANNELS = 8,
    parameter int SEL_W    = sel_width(CHANNELS)
) (
    input  logic [CHANNELS-1:0] mask_i,
    input  logic [SEL_W-1:0]    cur_i,
    output logic [SEL_W-1:0]    next_o,
    output logic                found_o
);

    int idx;

    // Walk offsets from farthest to nearest so the nearest enabled channel is
    // the last one written. Offset CHANNELS lands on cur_i itself, which is how
    // the lone-enabled-channel case returns the current index.
    always_comb begin
        next_o  = cur_i;
        found_o = 1'b0;
        idx     = 0;
        for (int off = CHANNELS; off >= 1; off--) begin
            idx = (int'(cur_i) + off) % CHANNELS;
            if (mask_i[idx]) begin
                next_o  = idx[SEL_W-1:0];
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_scan_sel.sv
// mux_scan_sel: registered CHANNELS:1 multiplexer of WIDTH-bit lanes with a
// host-loaded select register and an automatic dwell-timed scan mode.
//   clk, rst_n  clock (rising edge), asynchronous active-low reset
//   mode        0 = manual select, 1 = scan enabled channels
//   load        strobe: capture sel_in into cur_sel (either mode)
//   sel_in      requested channel
//   ch_en       per-channel enable mask
//   data_in     packed lanes, channel k at data_in[k*WIDTH +: WIDTH]
//   out         registered lane[cur_sel]
//   out_valid   registered ch_en[cur_sel]
//   cur_sel     current select register
//   sel_err     one-cycle pulse when a load names a nonexistent channel
module mux_scan_sel
    import mux_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = sel_width(CHANNELS),
    parameter int DWELL    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mode,
    input  logic                      load,
    input  logic [SEL_W-1:0]          sel_in,
    input  logic [CHANNELS-1:0]       ch_en,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    output logic [WIDTH-1:0]          out,
    output logic                      out_valid,
    output logic [SEL_W-1:0]          cur_sel,
    output logic                      sel_err
);

    localparam int              DW_W       = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);

    logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
    logic [DW_W-1:0]  dwell_q, dwell_d;
    logic             sel_err_q, sel_err_d;
    logic [WIDTH-1:0] out_q;
    logic             out_valid_q;

    logic [WIDTH-1:0] lanes [CHANNELS];
    logic [SEL_W-1:0] next_idx;
    logic             next_found;
    logic             sel_legal;
    sel_act_e         sel_act;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        assign lanes[k] = data_in[k*WIDTH +: WIDTH];
    end

    rr_next_finder #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_next (
        .mask_i  (ch_en),
        .cur_i   (cur_sel_q),
        .next_o  (next_idx),
        .found_o (next_found)
    );

    // Compared at 32 bits so the check stays meaningful (and lint-quiet) when
    // CHANNELS is a power of two and every encodable select is legal.
    assign sel_legal = (32'(sel_in) < 32'(CHANNELS));

    always_comb begin
        sel_act = ACT_HOLD;
        if (load) begin
            sel_act = sel_legal ? ACT_LOAD : ACT_REJECT;
        end else if (mode == MODE_SCAN) begin
            sel_act = ACT_SCAN;
        end
    end

    always_comb begin
        cur_sel_d = cur_sel_q;
        dwell_d   = '0;
        sel_err_d = 1'b0;
        case (sel_act)
            ACT_LOAD: begin
                cur_sel_d = sel_in;
            end
            ACT_REJECT: begin
                dwell_d   = dwell_q;
                sel_err_d = 1'b1;
            end
            ACT_SCAN: begin
                if (dwell_q == DWELL_LAST) begin
                    // Empty mask: hold the select but keep the dwell cycling.
                    if (next_found) begin
                        cur_sel_d = next_idx;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_sel_q   <= '0;
            dwell_q     <= '0;
            sel_err_q   <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            cur_sel_q   <= cur_sel_d;
            dwell_q     <= dwell_d;
            sel_err_q   <= sel_err_d;
            // Output stage samples the select as it stood before this edge.
            out_q       <= lanes[cur_sel_q];
            out_valid_q <= ch_en[cur_sel_q];
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign cur_sel   = cur_sel_q;
    assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_scan_sel.sv
module tb_mux_scan_sel;

    localparam int W  = 8;
    localparam int N8 = 8;
    localparam int N6 = 6;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 8-channel instance
    logic            mode, load;
    logic [2:0]      sel_in;
    logic [N8-1:0]   ch_en;
    logic [N8*W-1:0] data_in;
    logic [W-1:0]    out;
    logic            out_valid, sel_err;
    logic [2:0]      cur_sel;

    // 6-channel instance (non-power-of-two select space)
    logic            mode6, load6;
    logic [2:0]      sel_in6;
    logic [N6-1:0]   ch_en6;
    logic [N6*W-1:0] data_in6;
    logic [W-1:0]    out6;
    logic            out_valid6, sel_err6;
    logic [2:0]      cur_sel6;

    mux_scan_sel #(.WIDTH(W), .CHANNELS(N8), .DWELL(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .load(load), .sel_in(sel_in),
        .ch_en(ch_en), .data_in(data_in), .out(out), .out_valid(out_valid),
        .cur_sel(cur_sel), .sel_err(sel_err)
    );

    mux_scan_sel #(.WIDTH(W), .CHANNELS(N6), .DWELL(4)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .mode(mode6), .load(load6), .sel_in(sel_in6),
        .ch_en(ch_en6), .data_in(data_in6), .out(out6), .out_valid(out_valid6),
        .cur_sel(cur_sel6), .sel_err(sel_err6)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int seq [5];
        seq = '{0, 2, 5, 7, 0};

        rst_n  = 1'b0;
        mode   = 1'b0;  load  = 1'b0;  sel_in  = '0;  ch_en  = 8'hFF;
        mode6  = 1'b0;  load6 = 1'b0;  sel_in6 = '0;  ch_en6 = 6'h3F;
        for (int k = 0; k < N8; k++) data_in[k*W +: W]  = 8'(8'h10 + k);
        for (int k = 0; k < N6; k++) data_in6[k*W +: W] = 8'(8'h20 + k);

        // 1. reset values, then first registered output after release
        tick(3);
        chk("rst_out",       out,       8'h00);
        chk("rst_valid",     out_valid, 1'b0);
        chk("rst_cur",       cur_sel,   3'd0);
        chk("rst_err",       sel_err,   1'b0);
        chk("rst_cur6",      cur_sel6,  3'd0);
        rst_n = 1'b1;
        tick();
        chk("rel_out",       out,       8'h10);
        chk("rel_valid",     out_valid, 1'b1);
        chk("rel_cur",       cur_sel,   3'd0);

        // 2. manual load: select moves on the load edge, data one edge later
        load = 1'b1; sel_in = 3'd5;
        tick();
        chk("man_cur",       cur_sel,   3'd5);
        chk("man_out_lag",   out,       8'h10);
        load = 1'b0;
        tick();
        chk("man_out",       out,       8'h15);
        chk("man_valid",     out_valid, 1'b1);
        tick(5);
        chk("man_hold_cur",  cur_sel,   3'd5);
        chk("man_hold_out",  out,       8'h15);

        // 3. scan over mask 1010_0101: 0,2,5,7,0 each held 4 cycles
        ch_en = 8'hA5; load = 1'b1; sel_in = 3'd0;
        tick();
        load = 1'b0; mode = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            tick();
            chk($sformatf("scan_cur_%0d", c), cur_sel, 32'(seq[c/4]));
            chk($sformatf("scan_out_%0d", c), out, 32'(8'h10 + seq[(c-1)/4]));
        end
        chk("scan_valid",    out_valid, 1'b1);

        // 4a. only the current channel enabled: select stays put
        mode = 1'b0; ch_en = 8'h08; load = 1'b1; sel_in = 3'd3;
        tick();
        load = 1'b0; mode = 1'b1;
        tick();
        chk("solo_cur",      cur_sel,   3'd3);
        chk("solo_out",      out,       8'h13);
        chk("solo_valid",    out_valid, 1'b1);
        tick(6);
        chk("solo_cur_late", cur_sel,   3'd3);
        // 4b/4c. clear the selected channel's enable: valid drops next edge
        ch_en = 8'h00;
        tick();
        chk("dis_valid",     out_valid, 1'b0);
        chk("dis_out",       out,       8'h13);
        tick(9);
        chk("none_cur",      cur_sel,   3'd3);
        chk("none_valid",    out_valid, 1'b0);
        chk("none_err",      sel_err,   1'b0);

        // 5. load during scan at dwell 2 restarts the dwell
        ch_en = 8'hA5; load = 1'b1; sel_in = 3'd0;
        tick();
        chk("ld5_cur0",      cur_sel,   3'd0);
        load = 1'b0;
        tick(2);
        chk("ld5_pre",       cur_sel,   3'd0);
        load = 1'b1; sel_in = 3'd6;
        tick();
        chk("ld5_cur6",      cur_sel,   3'd6);
        load = 1'b0;
        tick(3);
        chk("ld5_hold",      cur_sel,   3'd6);
        tick();
        chk("ld5_adv",       cur_sel,   3'd7);
        tick();
        chk("ld5_out",       out,       8'h17);

        // scan -> manual freezes; manual -> scan advances DWELL edges later
        mode = 1'b0;
        tick(8);
        chk("frz_cur",       cur_sel,   3'd7);
        mode = 1'b1;
        tick(3);
        chk("resume_hold",   cur_sel,   3'd7);
        tick();
        chk("resume_wrap",   cur_sel,   3'd0);

        // 6. six-channel build: illegal select rejected with a one-cycle pulse
        load6 = 1'b1; sel_in6 = 3'd2;
        tick();
        chk("c6_cur",        cur_sel6,  3'd2);
        chk("c6_err0",       sel_err6,  1'b0);
        sel_in6 = 3'd7;
        tick();
        chk("c6_err_pulse",  sel_err6,  1'b1);
        chk("c6_cur_keep",   cur_sel6,  3'd2);
        chk("c6_out",        out6,      8'h22);
        load6 = 1'b0;
        tick();
        chk("c6_err_clr",    sel_err6,  1'b0);
        chk("c6_cur_keep2",  cur_sel6,  3'd2);

        // reset mid-scan clears everything without waiting for a clock edge
        mode6 = 1'b1;
        tick(2);
        chk("c6_mid",        cur_sel6,  3'd2);
        rst_n = 1'b0;
        #1;
        chk("arst_out6",     out6,       8'h00);
        chk("arst_valid6",   out_valid6, 1'b0);
        chk("arst_cur6",     cur_sel6,   3'd0);
        chk("arst_err6",     sel_err6,   1'b0);
        chk("arst_out",      out,        8'h00);
        chk("arst_valid",    out_valid,  1'b0);
        chk("arst_cur",      cur_sel,    3'd0);
        tick(2);
        rst_n = 1'b1;
        tick(3);
        chk("post_rst_hold6", cur_sel6, 3'd0);
        tick();
        chk("post_rst_adv6",  cur_sel6, 3'd1);
        chk("post_rst_adv8",  cur_sel,  3'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_scan_sel.md
Name: mux_scan_sel

Overview:
Parametrised, registered N-channel, W-bit multiplexer. Generalises the 8:1 single-bit gate-level mux.
Two modes:
- Manual: a host-loaded select register chooses the channel.
- Scan: a dwell counter steps automatically through the enabled channels, with wrap-around.
Sits between parallel sensor/data lanes and a single shared downstream consumer.

Parameters:
- WIDTH, 8, bits per channel.
- CHANNELS, 8, number of input channels (>=2).
- SEL_W, $clog2(CHANNELS), select width (derived; do not override).
- DWELL, 4, cycles each channel is held in scan mode (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  1  0 = manual, 1 = scan.
- load  in  1  one-cycle strobe: capture sel_in into cur_sel.
- sel_in  in  SEL_W  requested channel.
- ch_en  in  CHANNELS  per-channel enable mask.
- data_in  in  CHANNELS*WIDTH  packed lanes; channel k = data_in[k*WIDTH +: WIDTH].
- out  out  WIDTH  registered selected data.
- out_valid  out  1  registered: the channel that produced out was enabled.
- cur_sel  out  SEL_W  current select register.
- sel_err  out  1  one-cycle pulse: illegal load rejected.

Behaviour:
- Reset (async assert, sync release): cur_sel=0, dwell_cnt=0, out=0, out_valid=0, sel_err=0.
- Datapath, every edge:
  - out <= lane[cur_sel]; out_valid <= ch_en[cur_sel].
  - Latency: exactly 1 cycle from cur_sel or data change to out.
  - Disabled channel: out still updates, out_valid=0.
- Select update priority (highest first):
  1. load=1 and sel_in<CHANNELS: cur_sel <= sel_in; dwell_cnt <= 0. Applies in either mode.
  2. load=1 and sel_in>=CHANNELS: cur_sel and dwell_cnt unchanged; sel_err <= 1 for one cycle. Possible only when CHANNELS is not a power of 2.
  3. mode=1, no load: dwell_cnt increments. At dwell_cnt==DWELL-1:
     - dwell_cnt <= 0.
     - cur_sel <= next enabled index strictly after cur_sel, circular search, wrapping CHANNELS-1 -> 0.
  4. mode=0, no load: cur_sel holds; dwell_cnt <= 0.
- Scan boundary cases:
  - Only cur_sel enabled: search returns cur_sel; select holds, dwell restarts.
  - ch_en all zero: cur_sel holds, dwell keeps cycling, out_valid=0.
  - ch_en changing mid-dwell: no immediate effect; the new mask is used at the next advance decision.
  - DWELL=1: advance every cycle.
- Mode changes:
  - scan->manual: cur_sel frozen at its present value.
  - manual->scan: dwell_cnt starts from 0, so the first advance occurs DWELL cycles after the mode goes high.
- sel_err is 0 in every cycle without a rejected load.
- Reset mid-dwell: all state returns to reset values immediately; no partial advance.
- No handshake back-pressure: the consumer samples out when out_valid=1.

Decomposition:
- Package mux_pkg: mode encodings (MODE_MANUAL=0, MODE_SCAN=1) and the SEL_W derivation function.
- Sub-module rr_next_finder (combinational), parametrised on CHANNELS:
  - Inputs: mask, cur.
  - Outputs: next index, found flag.
  - Instantiated once.
- Top holds cur_sel, dwell_cnt, the output registers and the lane slicing.

Test Plan:
1. Reset with data_in lanes k=0x10+k, then release, mode=0, no load -> cur_sel=0, out=0x10, out_valid=1 one cycle after release.
2. Manual: load=1 with sel_in=5 -> cur_sel=5 on that edge; out=0x15 on the following edge; holds indefinitely.
3. Scan: DWELL=4, ch_en=8'b1010_0101 -> cur_sel sequence 0,2,5,7,0, each held 4 cycles; out lags cur_sel by 1 cycle.
4. Scan edge cases:
   - ch_en=8'b0000_1000 with cur_sel=3 -> stays 3.
   - ch_en=0 -> cur_sel holds, out_valid=0.
   - ch_en[3] cleared while cur_sel=3 -> out_valid=0 on the next edge.
5. Load during scan at dwell_cnt=2 with sel_in=6 -> cur_sel=6, dwell restarts; next advance after 4 cycles to the next enabled index above 6.
6. CHANNELS=6 build: load sel_in=7 -> sel_err pulses 1 cycle, cur_sel unchanged. Also assert rst_n mid-scan -> all outputs 0 asynchronously.
